// File: rtl/irq_pkg.sv
// Shared types and vector constants for the interrupt sequencer.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD_L = 3'd2,
    ST_RD_H = 3'd3,
    ST_LOAD = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_BRK   = 2'd2,
    SRC_IRQ   = 2'd3
  } src_e;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  // BRK shares the IRQ vector; B in the stacked P tells them apart.
  function automatic logic [15:0] vector_of(input src_e src);
    logic [15:0] vec;
    case (src)
      SRC_NMI:          vec = VEC_NMI;
      SRC_RESET:        vec = VEC_RESET;
      SRC_BRK, SRC_IRQ: vec = VEC_IRQ;
      default:          vec = VEC_RESET;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchronizer for an asynchronous active-low pin, with a
// single-cycle falling-edge pulse derived from the synchronized level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   prev_r;

  // Synchronizer chain plus one delayed copy for edge detection; idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {SYNC_STAGES{1'b1}};
      prev_r  <= 1'b1;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], din};
      prev_r  <= chain_r[SYNC_STAGES-1];
    end
  end

  assign sync = chain_r[SYNC_STAGES-1];
  assign fall = prev_r & ~chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt/reset sequencer: picks a source at instruction boundaries,
// handshakes with control, fetches the two vector bytes and loads PC.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic       brk_req,
  input  logic       inst_done,
  output logic       int_req,
  input  logic       int_ack,
  output logic       mem_req,
  output logic [7:0] mem_addr_h,
  output logic [7:0] mem_addr_l,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       pc_load,
  output logic [7:0] new_pc_h,
  output logic [7:0] new_pc_l,
  output logic       set_i,
  output logic       b_flag,
  output logic       busy
);

  state_e      state_r, state_s;
  src_e        src_r, src_s;
  logic        started_r;
  logic        nmi_pend_r;
  logic [7:0]  pcl_tmp_r;
  logic [7:0]  new_pc_h_r, new_pc_l_r;
  logic        nmi_sync_unused_s, nmi_fall_s;
  logic        irq_sync_s, irq_fall_unused_s;
  logic        nmi_now_s;
  logic        int_req_s, mem_req_s, pc_load_s, rd_h_s, busy_s;
  logic [15:0] vec_s;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk(clk), .rst_n(rst_n), .din(nmi_n),
    .sync(nmi_sync_unused_s), .fall(nmi_fall_s)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk(clk), .rst_n(rst_n), .din(irq_n),
    .sync(irq_sync_s), .fall(irq_fall_unused_s)
  );

  // An edge arriving on the same cycle as inst_done still wins arbitration.
  assign nmi_now_s = nmi_pend_r | nmi_fall_s;

  // State and source registers; reset parks the FSM at the reset-vector fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RD_L;
      src_r     <= SRC_RESET;
      started_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      src_r     <= src_s;
      started_r <= 1'b1;
    end
  end

  // Next-state and source selection with NMI > BRK > IRQ priority
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    case (state_r)
      ST_IDLE: begin
        if (inst_done) begin
          if (nmi_now_s) begin
            state_s = ST_REQ;
            src_s   = SRC_NMI;
          end else if (brk_req) begin
            state_s = ST_REQ;
            src_s   = SRC_BRK;
          end else if (!irq_sync_s && !i_flag) begin
            state_s = ST_REQ;
            src_s   = SRC_IRQ;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (int_ack) state_s = ST_RD_L;
        else         state_s = ST_REQ;
      end
      ST_RD_L: begin
        if (mem_req_s && mem_ack) state_s = ST_RD_H;
        else                      state_s = ST_RD_L;
      end
      ST_RD_H: begin
        if (mem_req_s && mem_ack) state_s = ST_LOAD;
        else                      state_s = ST_RD_H;
      end
      ST_LOAD: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode; the started flag keeps the bus quiet while reset is held
  always_comb begin
    int_req_s = 1'b0;
    mem_req_s = 1'b0;
    pc_load_s = 1'b0;
    rd_h_s    = 1'b0;
    busy_s    = 1'b0;
    case (state_r)
      ST_IDLE: busy_s = 1'b0;
      ST_REQ: begin
        int_req_s = 1'b1;
        busy_s    = 1'b1;
      end
      ST_RD_L: begin
        mem_req_s = started_r;
        busy_s    = started_r;
      end
      ST_RD_H: begin
        mem_req_s = started_r;
        rd_h_s    = 1'b1;
        busy_s    = started_r;
      end
      ST_LOAD: begin
        pc_load_s = 1'b1;
        busy_s    = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // NMI pending: a new edge always re-latches, even during its own service
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_pend_r <= 1'b0;
    end else if (nmi_fall_s) begin
      nmi_pend_r <= 1'b1;
    end else if (state_r == ST_REQ && int_ack && src_r == SRC_NMI) begin
      nmi_pend_r <= 1'b0;
    end
  end

  // Vector capture; new_pc changes only when the high byte completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcl_tmp_r  <= 8'h00;
      new_pc_h_r <= 8'h00;
      new_pc_l_r <= 8'h00;
    end else if (state_r == ST_RD_L && mem_req_s && mem_ack) begin
      pcl_tmp_r <= mem_data;
    end else if (state_r == ST_RD_H && mem_req_s && mem_ack) begin
      new_pc_h_r <= mem_data;
      new_pc_l_r <= pcl_tmp_r;
    end
  end

  assign vec_s      = vector_of(src_r);
  assign mem_addr_h = vec_s[15:8];
  assign mem_addr_l = vec_s[7:0] | {7'b0000000, rd_h_s};
  assign int_req    = int_req_s;
  assign mem_req    = mem_req_s;
  assign pc_load    = pc_load_s;
  assign set_i      = pc_load_s;
  assign busy       = busy_s;
  assign b_flag     = (src_r == SRC_BRK);
  assign new_pc_h   = new_pc_h_r;
  assign new_pc_l   = new_pc_l_r;

endmodule
